// File: rtl/cluster_pkg.sv
// cluster_pkg: shared widths, the cluster word type and the empty-slot test.
// A cluster word is {size, adr}; any adr at or above MXPADS is an empty slot.
package cluster_pkg;

    localparam int MXADRBITS  = 11;
    localparam int MXCLSTBITS = 3;
    localparam int MXPADS     = 1536;
    localparam int FIFO_DEPTH = 16;
    localparam int CLW        = MXADRBITS + MXCLSTBITS;

    localparam logic [MXADRBITS-1:0] EMPTY_ADR = 11'h7FE;

    typedef struct packed {
        logic [MXCLSTBITS-1:0] size;
        logic [MXADRBITS-1:0]  adr;
    } cluster_t;

    function automatic logic is_valid_cluster(input cluster_t c);
        return int'(c.adr) < MXPADS;
    endfunction

endpackage

// File: rtl/cluster_fifo_2w1r.sv
// cluster_fifo_2w1r: 2-write/1-read cluster FIFO with a registered head.
// Ports: clock4x, reset_n (async low), push0/push1 + d0/d1 (push1 implies
// push0, d0 is the older word), free_cnt, pop, head, empty.
module cluster_fifo_2w1r
    import cluster_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clock4x,
    input  logic                   reset_n,
    input  logic                   push0,
    input  logic                   push1,
    input  logic [CLW-1:0]         d0,
    input  logic [CLW-1:0]         d1,
    output logic [$clog2(DEPTH):0] free_cnt,
    input  logic                   pop,
    output logic [CLW-1:0]         head,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    // The head register is one of the DEPTH slots, so the array never
    // holds more than DEPTH-1 entries; it is sized DEPTH so the
    // pointers wrap for free.
    cluster_t      mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   mem_cnt;
    cluster_t      head_q;
    logic          head_vld;

    logic          take_head;
    logic          from_mem;
    logic          from_in;
    logic          wr0;
    logic          wr1;
    logic [AW-1:0] wr_adr1;
    logic [AW:0]   n_wr;

    // Head slot refills when empty or being popped; the array has
    // priority, and the head is only ever empty when the array is empty.
    assign take_head = !head_vld || pop;
    assign from_mem  = take_head && (mem_cnt != '0);
    assign from_in   = take_head && (mem_cnt == '0) && push0;

    assign wr0     = push0 && !from_in;
    assign wr1     = push1;
    assign wr_adr1 = wr0 ? wr_ptr + 1'b1 : wr_ptr;
    assign n_wr    = (AW+1)'(wr0) + (AW+1)'(wr1);

    assign free_cnt = (AW+1)'(DEPTH) - mem_cnt - (AW+1)'(head_vld);
    assign head     = head_q;
    assign empty    = !head_vld;

    always_ff @(posedge clock4x) begin
        if (wr0) begin
            mem[wr_ptr] <= cluster_t'(d0);
        end
        if (wr1) begin
            mem[wr_adr1] <= cluster_t'(d1);
        end
    end

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            mem_cnt  <= '0;
            head_q   <= '0;
            head_vld <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(n_wr);
            mem_cnt <= mem_cnt + n_wr - (AW+1)'(from_mem);
            if (from_mem) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (take_head) begin
                head_vld <= from_mem || from_in;
                if (from_mem) begin
                    head_q <= mem[rd_ptr];
                end else if (from_in) begin
                    head_q <= cluster_t'(d0);
                end
            end
        end
    end

endmodule

// File: rtl/cluster_unpacker.sv
// cluster_unpacker: rebuilds per-BX cluster count/overflow from a 4-cycle,
// 2-word frame and streams valid clusters out through a FIFO (valid/ready).
// Ports: clock4x, reset_n, din_valid, bx_start, din, ovf_in, m_valid/m_ready,
// m_adr, m_size, frame_done, frame_cnt, frame_ovf, frame_err, drop_cnt.
module cluster_unpacker
    import cluster_pkg::*;
(
    input  logic                  clock4x,
    input  logic                  reset_n,
    input  logic                  din_valid,
    input  logic                  bx_start,
    input  logic [2*CLW-1:0]      din,
    input  logic                  ovf_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [MXADRBITS-1:0]  m_adr,
    output logic [MXCLSTBITS-1:0] m_size,
    output logic                  frame_done,
    output logic [3:0]            frame_cnt,
    output logic                  frame_ovf,
    output logic                  frame_err,
    output logic [7:0]            drop_cnt
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [0:0]    state;
    logic [1:0]    phase;
    logic [3:0]    acc;
    logic          ovf_acc;

    cluster_t      w0;
    cluster_t      w1;
    logic          accept;
    logic          start;
    logic          v0;
    logic          v1;
    logic [1:0]    n_valid;
    logic [3:0]    inc;

    logic          push0;
    logic          push1;
    logic [CLW-1:0] d0;
    logic [FW-1:0] free_cnt;
    logic [1:0]    n_push;
    logic [1:0]    n_drop;
    logic [8:0]    drop_sum;

    logic          pop;
    logic          fifo_empty;
    logic [CLW-1:0] head_bits;

    assign w0 = cluster_t'(din[CLW-1:0]);
    assign w1 = cluster_t'(din[2*CLW-1:CLW]);

    // Words count (and get queued) only when they belong to a frame:
    // any cycle of a running frame, or a qualified frame start.
    assign start   = din_valid && bx_start;
    assign accept  = din_valid && (bx_start || state == COLLECT);
    assign v0      = accept && is_valid_cluster(w0);
    assign v1      = accept && is_valid_cluster(w1);
    assign n_valid = {1'b0, v0} + {1'b0, v1};
    assign inc     = 4'(n_valid);

    // Room is judged before this cycle's pop; the older word wins a
    // single free slot.
    assign push0    = (v0 || v1) && (free_cnt != '0);
    assign push1    = v0 && v1 && (free_cnt > FW'(1));
    assign d0       = v0 ? CLW'(w0) : CLW'(w1);
    assign n_push   = {1'b0, push0} + {1'b0, push1};
    assign n_drop   = n_valid - n_push;
    assign drop_sum = {1'b0, drop_cnt} + 9'(n_drop);

    always_ff @(posedge clock4x or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clock4x or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= 2'd0;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            frame_ovf  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COLLECT;
                        phase   <= 2'd1;
                        acc     <= inc;
                        ovf_acc <= ovf_in;
                    end
                end
                COLLECT: begin
                    if (!din_valid) begin
                        state     <= IDLE;
                        phase     <= 2'd0;
                        frame_err <= 1'b1;
                    end else if (bx_start) begin
                        // Early start: drop the partial frame, this
                        // cycle becomes phase 0 of the next one.
                        phase     <= 2'd1;
                        acc       <= inc;
                        ovf_acc   <= ovf_in;
                        frame_err <= 1'b1;
                    end else if (phase == 2'd3) begin
                        state      <= IDLE;
                        phase      <= 2'd0;
                        frame_done <= 1'b1;
                        frame_cnt  <= acc + inc;
                        frame_ovf  <= ovf_acc | ovf_in;
                    end else begin
                        phase   <= phase + 2'd1;
                        acc     <= acc + inc;
                        ovf_acc <= ovf_acc | ovf_in;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    cluster_fifo_2w1r #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock4x  (clock4x),
        .reset_n  (rst_n),
        .push0    (push0),
        .push1    (push1),
        .d0       (d0),
        .d1       (CLW'(w1)),
        .free_cnt (free_cnt),
        .pop      (pop),
        .head     (head_bits),
        .empty    (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign m_adr   = head_bits[MXADRBITS-1:0];
    assign m_size  = head_bits[CLW-1:MXADRBITS];

endmodule
